// File: rtl/board_state_tracker_pkg.sv
// Shared definitions for the 4x4 Connect4 board tracker: geometry,
// FSM state and player encodings, win-line masks and a small
// counter helper.
package board_state_tracker_pkg;

  localparam int COLS = 4;
  localparam int ROWS = 4;
  localparam logic [4:0] INVALID_POS = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_CHECK  = 2'd2,
    ST_OVER   = 2'd3
  } state_e;

  typedef enum logic {
    PLAYER1 = 1'b0,
    PLAYER2 = 1'b1
  } player_e;

  // Four-in-a-line masks over cell index row*4+col.
  localparam logic [15:0] ROW_MASK0  = 16'h000F;
  localparam logic [15:0] COL_MASK0  = 16'h1111;
  localparam logic [15:0] DIAG_MASK  = 16'h8421;
  localparam logic [15:0] ANTI_MASK  = 16'h1248;

  // Column fill count increment that never passes ROWS.
  function automatic logic [2:0] cnt_inc(input logic [2:0] c);
    return (c < 3'(ROWS)) ? c + 3'd1 : c;
  endfunction

endpackage

// File: rtl/board_state_tracker_if.sv
// Move/board bus between the control/calculator side (master) and the
// board state tracker (slave). The winner signal exists only in
// builds with WIN_DETECT_EN defined.
interface board_state_tracker_if;

  logic        enable;
  logic        new_game;
  logic        move_strobe;
  logic [4:0]  column_position;
  logic        add;
  logic [11:0] counters;
  logic [15:0] board_p1;
  logic [15:0] board_p2;
  logic        current_player;
  logic        move_done;
  logic        illegal_move;
  logic        board_full;
  logic        game_over;
`ifdef WIN_DETECT_EN
  logic [1:0]  winner;
`endif

  modport master (
    output enable, new_game, move_strobe, column_position, add,
    input  counters, board_p1, board_p2, current_player,
    input  move_done, illegal_move, board_full, game_over
`ifdef WIN_DETECT_EN
    , input winner
`endif
  );

  modport slave (
    input  enable, new_game, move_strobe, column_position, add,
    output counters, board_p1, board_p2, current_player,
    output move_done, illegal_move, board_full, game_over
`ifdef WIN_DETECT_EN
    , output winner
`endif
  );

endinterface

// File: rtl/board_state_tracker_win_checker.sv
// Combinational four-in-a-line detector for one player's 16-bit board
// (4 rows, 4 columns, 2 diagonals). Only compiled with WIN_DETECT_EN.
`ifdef WIN_DETECT_EN
module board_win_checker
  import board_state_tracker_pkg::*;
(
  input  logic [15:0] board_i,
  output logic        win_o
);

  // Any fully covered line mask is a win.
  always_comb begin
    win_o = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      if ((board_i & (ROW_MASK0 << (4 * r))) == (ROW_MASK0 << (4 * r))) win_o = 1'b1;
    end
    for (int c = 0; c < COLS; c++) begin
      if ((board_i & (COL_MASK0 << c)) == (COL_MASK0 << c)) win_o = 1'b1;
    end
    if ((board_i & DIAG_MASK) == DIAG_MASK) win_o = 1'b1;
    if ((board_i & ANTI_MASK) == ANTI_MASK) win_o = 1'b1;
  end

endmodule
`endif

// File: rtl/board_state_tracker.sv
// Connect4 board state tracker: edge-detects the drop strobe, validates
// the calculator's cell against the column counters, commits the piece
// into the mover's board, alternates turns and flags full/game over.
// Optional macro WIN_DETECT_EN adds four-in-a-line detection and the
// winner output.
module board_state_tracker
  import board_state_tracker_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  board_state_tracker_if.slave  bus
);

  state_e                  state_q, state_d;
  logic                    strobe_q;
  logic [3:0]              pos_q, pos_d;
  logic [15:0]             p1_q, p1_d;
  logic [15:0]             p2_q, p2_d;
  logic [COLS-1:0][2:0]    cnt_q, cnt_d;
  player_e                 player_q, player_d;
  logic                    done_q, done_d;
  logic                    illegal_q, illegal_d;
  logic                    full_q, full_d;

  logic                    rise_w;
  logic [1:0]              col_w;
  logic [2:0]              row_w;
  logic [2:0]              cnt_sel_w;
  logic [3:0]              cell_w;
  logic                    occupied_w;
  logic                    accept_w;
  logic                    full_w;
  logic                    win_w;

`ifdef WIN_DETECT_EN
  logic [1:0]              winner_q, winner_d;
  logic [15:0]             mover_board_w;

  // In CHECK the mover's board already holds the committed piece.
  assign mover_board_w = (player_q == PLAYER2) ? p2_q : p1_q;

  board_win_checker u_win (
    .board_i (mover_board_w),
    .win_o   (win_w)
  );

  assign bus.winner = winner_q;
`else
  assign win_w = 1'b0;
`endif

  assign rise_w     = bus.move_strobe & ~strobe_q;
  assign col_w      = bus.column_position[1:0];
  assign row_w      = bus.column_position[4:2];
  assign cell_w     = bus.column_position[3:0];
  assign cnt_sel_w  = cnt_q[col_w];
  assign occupied_w = p1_q[cell_w] | p2_q[cell_w];
  assign full_w     = &(p1_q | p2_q);

  // A drop is legal only onto the lowest free cell of a non-full column.
  assign accept_w = bus.add
                  && (bus.column_position != INVALID_POS)
                  && (row_w == cnt_sel_w)
                  && (cnt_sel_w < 3'(ROWS))
                  && !occupied_w;

  // State and board registers; strobe history tracks every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      strobe_q  <= 1'b0;
      pos_q     <= '0;
      p1_q      <= '0;
      p2_q      <= '0;
      cnt_q     <= '0;
      player_q  <= PLAYER1;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      full_q    <= 1'b0;
`ifdef WIN_DETECT_EN
      winner_q  <= 2'b00;
`endif
    end else begin
      state_q   <= state_d;
      strobe_q  <= bus.move_strobe;
      pos_q     <= pos_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      cnt_q     <= cnt_d;
      player_q  <= player_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      full_q    <= full_d;
`ifdef WIN_DETECT_EN
      winner_q  <= winner_d;
`endif
    end
  end

  // Next-state logic: accept/reject, commit, end-of-move evaluation.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    p1_d      = p1_q;
    p2_d      = p2_q;
    cnt_d     = cnt_q;
    player_d  = player_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    full_d    = full_q;
`ifdef WIN_DETECT_EN
    winner_d  = winner_q;
`endif

    if (bus.new_game) begin
      state_d  = ST_IDLE;
      pos_d    = '0;
      p1_d     = '0;
      p2_d     = '0;
      cnt_d    = '0;
      player_d = PLAYER1;
      full_d   = 1'b0;
`ifdef WIN_DETECT_EN
      winner_d = 2'b00;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.enable && rise_w) begin
            if (accept_w) begin
              pos_d   = cell_w;
              state_d = ST_COMMIT;
            end else begin
              illegal_d = 1'b1;
            end
          end
        end
        ST_COMMIT: begin
          if (player_q == PLAYER2) p2_d = p2_q | (16'h0001 << pos_q);
          else                     p1_d = p1_q | (16'h0001 << pos_q);
          cnt_d[pos_q[1:0]] = cnt_inc(cnt_q[pos_q[1:0]]);
          state_d = ST_CHECK;
        end
        ST_CHECK: begin
          full_d   = full_w;
          done_d   = 1'b1;
          player_d = (player_q == PLAYER1) ? PLAYER2 : PLAYER1;
          state_d  = (full_w || win_w) ? ST_OVER : ST_IDLE;
`ifdef WIN_DETECT_EN
          if (win_w)       winner_d = (player_q == PLAYER2) ? 2'b10 : 2'b01;
          else if (full_w) winner_d = 2'b11;
          else             winner_d = 2'b00;
`endif
        end
        default: begin
          state_d = ST_OVER;
        end
      endcase
    end
  end

  assign bus.counters       = cnt_q;
  assign bus.board_p1       = p1_q;
  assign bus.board_p2       = p2_q;
  assign bus.current_player = player_q;
  assign bus.move_done      = done_q;
  assign bus.illegal_move   = illegal_q;
  assign bus.board_full     = full_q;
  assign bus.game_over      = (state_q == ST_OVER);

endmodule

// File: tb/tb_board_state_tracker.sv
// Bench for board_state_tracker: directed scenarios plus randomized play
// checked against a grid/height model of the game rules.
module tb_board_state_tracker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  board_state_tracker_if bus ();

  board_state_tracker dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference game model: grid[row][col] holds 0 empty, 1 p1, 2 p2.
  int grid [4][4];
  int height [4];
  int m_player;
  bit m_over;
  bit m_full;
  int m_winner;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] board_of(input int p);
    logic [15:0] b = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (grid[r][c] == p) b[r*4 + c] = 1'b1;
    return b;
  endfunction

  function automatic logic [11:0] cnt_word();
    logic [11:0] w = '0;
    for (int c = 0; c < 4; c++) w[c*3 +: 3] = 3'(height[c]);
    return w;
  endfunction

  function automatic bit has_line(input int p);
    bit hit = 0;
    bit all;
    for (int r = 0; r < 4; r++) begin
      all = 1;
      for (int c = 0; c < 4; c++) if (grid[r][c] != p) all = 0;
      if (all) hit = 1;
    end
    for (int c = 0; c < 4; c++) begin
      all = 1;
      for (int r = 0; r < 4; r++) if (grid[r][c] != p) all = 0;
      if (all) hit = 1;
    end
    all = 1;
    for (int i = 0; i < 4; i++) if (grid[i][i] != p) all = 0;
    if (all) hit = 1;
    all = 1;
    for (int i = 0; i < 4; i++) if (grid[i][3-i] != p) all = 0;
    if (all) hit = 1;
    return hit;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) grid[r][c] = 0;
    for (int c = 0; c < 4; c++) height[c] = 0;
    m_player = 0;
    m_over   = 0;
    m_full   = 0;
    m_winner = 0;
  endtask

  task automatic model_end_of_move();
    int  filled = 0;
    bit  win = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) if (grid[r][c] != 0) filled++;
    m_full = (filled == 16);
`ifdef WIN_DETECT_EN
    win = has_line(m_player + 1);
`endif
    if (win)         m_winner = (m_player == 0) ? 1 : 2;
    else if (m_full) m_winner = 3;
    else             m_winner = 0;
    if (win || m_full) m_over = 1;
    m_player = 1 - m_player;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "/board_p1"}, bus.board_p1, board_of(1));
    chk({tag, "/board_p2"}, bus.board_p2, board_of(2));
    chk({tag, "/counters"}, bus.counters, cnt_word());
    chk({tag, "/player"}, bus.current_player, m_player);
    chk({tag, "/board_full"}, bus.board_full, m_full);
    chk({tag, "/game_over"}, bus.game_over, m_over);
`ifdef WIN_DETECT_EN
    chk({tag, "/winner"}, bus.winner, m_winner);
`endif
  endtask

  // One button press held for `hold` cycles, checked cycle by cycle.
  task automatic press(input int pos, input bit addv, input bit en, input int hold, input string tag);
    bit legal = 0;
    bit eff;
    int n;
    @(negedge clk);
    bus.enable          = en;
    bus.column_position = 5'(pos);
    bus.add             = addv;
    bus.move_strobe     = 1'b1;
    eff = en && !m_over;
    if (addv && pos != 31 && pos < 16) begin
      if ((pos / 4) == height[pos % 4] && height[pos % 4] < 4 && grid[pos / 4][pos % 4] == 0)
        legal = 1;
    end
    n = ((hold > 4) ? hold : 4) + 1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (eff && legal && i == 1) begin
        grid[pos / 4][pos % 4] = m_player + 1;
        height[pos % 4]++;
      end
      if (eff && legal && i == 2) model_end_of_move();
      chk({tag, "/illegal_move"}, bus.illegal_move, (eff && !legal && i == 0));
      chk({tag, "/move_done"}, bus.move_done, (eff && legal && i == 2));
      check_state(tag);
      if (i == hold - 1) bus.move_strobe = 1'b0;
    end
    bus.enable = 1'b1;
  endtask

  task automatic play_col(input int c, input int hold, input string tag);
    int pos = (height[c] < 4) ? height[c] * 4 + c : 31;
    press(pos, 1'b1, 1'b1, hold, tag);
  endtask

  task automatic new_game_pulse(input string tag);
    @(negedge clk);
    bus.new_game = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
    check_state(tag);
    chk({tag, "/move_done"}, bus.move_done, 1'b0);
    @(negedge clk);
    bus.new_game = 1'b0;
  endtask

  int draw_cols [16] = '{0, 0, 0, 0, 1, 2, 2, 3, 3, 1, 1, 2, 2, 3, 3, 1};
  int win_cols  [7]  = '{0, 0, 1, 0, 2, 0, 3};

  initial begin
    bus.enable          = 1'b1;
    bus.new_game        = 1'b0;
    bus.move_strobe     = 1'b0;
    bus.column_position = 5'd0;
    bus.add             = 1'b0;
    rst_n               = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    chk("reset/move_done", bus.move_done, 1'b0);
    chk("reset/illegal_move", bus.illegal_move, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic moves and rejections.
    press(0, 1'b1, 1'b1, 1, "first_move");
    press(8, 1'b1, 1'b1, 1, "row_mismatch");
    press(4, 1'b1, 1'b1, 2, "second_move");
    press(31, 1'b0, 1'b1, 1, "invalid_pos");
    press(5, 1'b1, 1'b1, 1, "floating_cell");
    press(1, 1'b1, 1'b1, 10, "held_button");
    press(2, 1'b1, 1'b0, 1, "disabled");
    press(2, 1'b1, 1'b1, 3, "after_enable");

    // Draw: fill the board with no four-in-a-line.
    new_game_pulse("ng_draw");
    foreach (draw_cols[k]) play_col(draw_cols[k], 1, "draw_fill");
    press(31, 1'b0, 1'b1, 1, "over_illegal");
    press(0, 1'b1, 1'b1, 1, "over_strobe");
    new_game_pulse("ng_after_draw");

    // p1 completes row 0 while p2 stacks column 0.
    foreach (win_cols[k]) play_col(win_cols[k], 1, "row_win");
    press(13, 1'b1, 1'b1, 1, "after_win");
    new_game_pulse("ng_after_win");

    // Reset in the middle of an accepted move.
    @(negedge clk);
    bus.column_position = 5'd0;
    bus.add             = 1'b1;
    bus.move_strobe     = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    model_clear();
    check_state("reset_mid_move");
    @(negedge clk);
    bus.move_strobe = 1'b0;
    rst_n           = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_state("after_reset_mid");

    // Randomized games.
    for (int g = 0; g < 6; g++) begin
      for (int m = 0; m < 40; m++) begin
        int sel = $urandom_range(0, 9);
        int c   = $urandom_range(0, 3);
        int h   = $urandom_range(1, 6);
        if (sel == 0)
          press($urandom_range(0, 31), 1'($urandom_range(0, 1)), 1'b1, h, "rand_any");
        else if (sel == 1)
          press((height[c] < 4) ? height[c] * 4 + c : 31, 1'b1, 1'b0, h, "rand_disabled");
        else
          play_col(c, h, "rand_legal");
      end
      new_game_pulse("rand_new_game");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/board_state_tracker.md
Name: board_state_tracker

Overview:
- Sits directly downstream of the column calculator in the 4x4 Connect4 datapath.
- Consumes the calculator's `column_position` / `add` result on each player move strobe and commits the piece into per-player board registers.
- Owns the four 3-bit column fill counters and feeds them back to the calculator.
- Alternates turns and flags board-full / game-over to the display and control logic.

Parameters:
- COLS, 4, number of columns (fixed geometry; counters are 3 bits per column).
- ROWS, 4, number of rows; a column counter value of ROWS means the column is full.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  game active; when 0, strobes are ignored and the FSM holds in IDLE.
- new_game  in  1  synchronous clear of the board, counters and turn; priority over all other inputs.
- move_strobe  in  1  level from the debounced drop button; the block edge-detects it internally.
- column_position  in  5  cell index from the calculator, row*4+col; 5'b11111 = invalid.
- add  in  1  calculator's valid flag.
- counters  out  12  column fill counts, col0 in [2:0] ... col3 in [11:9]; fed back to the calculator.
- board_p1  out  16  cell occupancy for player 1, bit = cell index.
- board_p2  out  16  cell occupancy for player 2.
- current_player  out  1  0 = player 1, 1 = player 2.
- move_done  out  1  one-cycle pulse when a move commits.
- illegal_move  out  1  one-cycle pulse when a strobe is rejected.
- board_full  out  1  all 16 cells occupied.
- game_over  out  1  sticky until new_game or reset.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - counters=0, board_p1=0, board_p2=0, current_player=0.
  - move_done=0, illegal_move=0, board_full=0, game_over=0.
  - State=IDLE; the strobe edge register is cleared.
- Strobe edge detection: rise = move_strobe & ~strobe_q, where strobe_q is registered every cycle.
- IDLE, on edge k with enable=1 and rise=1:
  - Accept if add=1, column_position != 31, row (pos[4:2]) == counter[col] with col = pos[1:0], counter[col] < ROWS, and the cell is not set in either board.
  - On accept: latch pos into pos_q and go to COMMIT.
  - Otherwise: illegal_move=1 for the cycle after edge k; stay in IDLE.
- COMMIT, edge k+1:
  - Set bit pos_q in the current player's board.
  - counter[col] += 1 (saturating at ROWS; the acceptance rule already prevents overflow).
  - Go to CHECK.
- CHECK, edge k+2:
  - Evaluate board_full (p1|p2 == 16'hFFFF) and the end condition.
  - move_done=1 for exactly one cycle.
  - current_player toggles.
  - Next state is OVER if the end condition holds, else IDLE.
- OVER: game_over=1; all strobes ignored (no illegal_move pulse); exits only on new_game or reset.
- Latency: strobe edge to board update visible = 2 edges; to move_done = 3 edges.
- Strobes during COMMIT/CHECK are ignored. strobe_q still tracks, so a held button never retriggers.
- new_game in any state: next edge restores all reset values and goes to IDLE. It wins over a simultaneous strobe.
- enable deasserted during COMMIT/CHECK: the in-flight move completes; new strobes are ignored until enable=1.
- Reset mid-move: the move is lost, with no partial board or counter update.

Optional Feature:
- Macro: WIN_DETECT_EN.
- Defined:
  - CHECK evaluates four-in-a-line for the mover's updated board: 4 rows, 4 columns, 2 diagonals (masks 16'h000F<<4r, 16'h1111<<c, 16'h8421, 16'h1248).
  - End condition = win | board_full.
  - Extra output `winner[1:0]`: 00 none, 01 p1, 10 p2, 11 draw (full, no win). It is set in CHECK and held in OVER.
- Undefined: end condition = board_full only; no `winner` port.

Decomposition:
- Shared package/header `connect4_defs`:
  - COLS, ROWS, INVALID_POS (5'd31).
  - State encodings IDLE/COMMIT/CHECK/OVER.
  - Player codes.
  - Win-line mask constants.
- One natural sub-module: `board_win_checker`, combinational, 16-bit board in, win flag out. It is instantiated only under WIN_DETECT_EN.

Test Plan:
- Reset, then strobe with pos=0, add=1 -> board_p1=16'h0001 two edges later, counters=12'h001, move_done on the third edge, current_player=1.
- Second strobe pos=4 (col0 row1) -> board_p2=16'h0010, counters[2:0]=2, current_player=0.
- Strobe with pos=31, add=0 -> illegal_move single pulse; boards, counters and player unchanged.
- Strobe with pos=8 while counters[2:0]=1 (row mismatch) -> illegal_move; no update.
- Button held high for 10 cycles -> exactly one commit. Strobe during COMMIT -> ignored.
- Fill all 16 cells alternately with no 4-line -> board_full=1, game_over=1, winner=11 (WIN_DETECT_EN); further strobes ignored; new_game -> all cleared, IDLE.
- WIN_DETECT_EN, p1 plays cols 0,1,2,3 in row0 with p2 stacking on col0 -> after p1's 4th move, game_over=1, winner=01, board_p1[3:0]=4'hF.
